// File: rtl/wb_pkg.sv
// Shared opcodes, FSM state type and decode helpers for the writeback stage.
// Pure declarations: no logic, no latency, no flow control.
// Imported by writeback_stage and load_align.
package wb_pkg;

    localparam logic [5:0] JAL_OP  = 6'b100000;
    localparam logic [5:0] JALR_OP = 6'b010001;
    localparam logic [5:0] LB_OP   = 6'b010101;
    localparam logic [5:0] LBU_OP  = 6'b011000;
    localparam logic [5:0] LH_OP   = 6'b010110;
    localparam logic [5:0] LHU_OP  = 6'b011001;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

    function automatic logic is_link_op(input logic [5:0] op);
        return (op == JAL_OP) || (op == JALR_OP);
    endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian byte/halfword lane select with sign/zero extension for loads.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        byte_off,
    input  logic [5:0]        aluop,
    output logic [DATA_W-1:0] ext_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = data[DATA_W-1 -: 8];
        case (byte_off)
            2'd0:    lane_b = data[DATA_W-1  -: 8];
            2'd1:    lane_b = data[DATA_W-9  -: 8];
            2'd2:    lane_b = data[DATA_W-17 -: 8];
            default: lane_b = data[DATA_W-25 -: 8];
        endcase
    end

    // Halfword lane ignores byte_off[0]; offset 0 is the upper half.
    assign lane_h = byte_off[1] ? data[DATA_W-17 -: 16] : data[DATA_W-1 -: 16];

    always_comb begin
        ext_data = data;
        case (aluop)
            LB_OP:   ext_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
            LBU_OP:  ext_data = {{(DATA_W-8){1'b0}}, lane_b};
            LH_OP:   ext_data = {{(DATA_W-16){lane_h[15]}}, lane_h};
            LHU_OP:  ext_data = {{(DATA_W-16){1'b0}}, lane_h};
            default: ext_data = data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Register-file writeback: selects destination/data, aligns loads, strobes rf_we.
// Latency: 1 cycle from accept (or from dmem_valid for a waiting load) to rf_we.
// Backpressure: in_ready low while a load waits for DMEM data; holds indefinitely.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       insn,
    input  logic [5:0]        aluop,
    input  logic [DATA_W-1:0] alu_o,
    input  logic              rwd,
    input  logic              rdst,
    input  logic              rwe,
    input  logic [1:0]        byte_off,
    input  logic [DATA_W-1:0] dmem_d,
    input  logic              dmem_valid,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pend_valid,
    output logic [REG_AW-1:0] pend_addr
);

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [5:0]        op;
        logic [1:0]        byte_off;
        logic              we;
    } pend_t;

    wb_state_e         state_q, state_d;
    pend_t             pend_q;
    logic              accept, link, is_load;
    logic              commit, capture, waiting;
    logic [REG_AW-1:0] cur_dest, wr_dest;
    logic              wr_en_src, do_write;
    logic [5:0]        al_op;
    logic [1:0]        al_off;
    logic [DATA_W-1:0] al_data, wr_data;
    logic              unused_insn;

    assign unused_insn = ^{insn[31:21], insn[10:0]};

    assign waiting  = (state_q == WAIT_MEM);
    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign link     = is_link_op(aluop);
    // Link ops carry PC+8 in alu_o even when rwd is set, so they never wait on DMEM.
    assign is_load  = rwd && !link;

    always_comb begin
        cur_dest = rdst ? REG_AW'(insn[15:11]) : REG_AW'(insn[20:16]);
        if (link) begin
            cur_dest = REG_AW'(LINK_REG);
        end
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_load && !dmem_valid) begin
                        capture = 1'b1;
                        state_d = WAIT_MEM;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (dmem_valid) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign al_op  = waiting ? pend_q.op       : aluop;
    assign al_off = waiting ? pend_q.byte_off : byte_off;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .data     (dmem_d),
        .byte_off (al_off),
        .aluop    (al_op),
        .ext_data (al_data)
    );

    always_comb begin
        wr_dest   = cur_dest;
        wr_en_src = rwe;
        wr_data   = (link || !rwd) ? alu_o : al_data;
        if (waiting) begin
            wr_dest   = pend_q.dest;
            wr_en_src = pend_q.we;
            wr_data   = al_data;
        end
    end

    // r0 commits still advance the FSM but never strobe the register file.
    assign do_write = commit && wr_en_src && (wr_dest != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state_q <= state_d;
            rf_we   <= do_write;
            if (do_write) begin
                rf_waddr <= wr_dest;
                rf_wdata <= wr_data;
            end
            if (capture) begin
                pend_q <= '{dest: cur_dest, op: aluop, byte_off: byte_off, we: rwe};
            end
        end
    end

    assign pend_valid = waiting;
    assign pend_addr  = pend_q.dest;

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DATA_W, default 32: datapath width in bits; SHALL be a multiple of 16.
REQ-002 Parameter REG_AW, default 5: register-file address width.
REQ-003 Parameter LINK_REG, default 31: destination index for JAL/JALR link writes.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream has a retiring instruction this cycle.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 insn  input  32  retiring instruction word; rt = [20:16], rd = [15:11].
REQ-009 aluop  input  6  decoded operation code.
REQ-010 alu_o  input  DATA_W  ALU result, or PC+8 for link operations.
REQ-011 rwd, rdst, rwe  input  1 each  select DMEM data, select rd over rt, register write enable.
REQ-012 byte_off  input  2  low address bits of a load.
REQ-013 dmem_d  input  DATA_W  DMEM read data.
REQ-014 dmem_valid  input  1  dmem_d is valid this cycle.
REQ-015 rf_we  output  1  register-file write strobe.
REQ-016 rf_waddr  output  REG_AW  write address.
REQ-017 rf_wdata  output  DATA_W  write data.
REQ-018 pend_valid, pend_addr  output  1, REG_AW  a load is waiting for data, and its destination register.

Function
REQ-019 Accept SHALL occur when in_valid and in_ready are both high; in_ready SHALL be high only in state IDLE.
REQ-020 Destination SHALL be insn[15:11] if rdst=1, else insn[20:16].
REQ-021 Destination SHALL be LINK_REG and data SHALL be alu_o for JAL_OP or JALR_OP, regardless of rdst and rwd.
REQ-022 Data SHALL be alu_o if rwd=0, else the load-extracted dmem_d.
REQ-023 Byte lanes SHALL be big-endian: byte_off 0 selects bits [DATA_W-1:DATA_W-8].
REQ-024 Halfword offset SHALL use byte_off[1] only, with offset 0 selecting the upper half.
REQ-025 Loads SHALL extend as follows: LB sign-extend the byte, LBU zero-extend the byte, LH sign-extend the halfword, LHU zero-extend the halfword; any other op with rwd=1 SHALL pass the full word.
REQ-026 FSM states SHALL be IDLE and WAIT_MEM.
REQ-027 In IDLE, an accepted op that is not a load, or a load accepted with dmem_valid=1 in the same cycle, SHALL produce a write on the next cycle (1-cycle latency).
REQ-028 In IDLE, a load accepted with dmem_valid=0 SHALL move the FSM to WAIT_MEM and capture the destination, op and byte_off.
REQ-029 In WAIT_MEM, dmem_valid=1 SHALL produce the write on the next cycle and return the FSM to IDLE.
REQ-030 In WAIT_MEM, the block SHALL hold indefinitely, with pend_valid=1 and pend_addr equal to the captured destination.
REQ-031 rf_we SHALL pulse for exactly one cycle per committed instruction, and only when rwe=1 and the destination is nonzero; r0 writes SHALL be suppressed while the FSM still advances.
REQ-032 When rf_we=0, rf_waddr and rf_wdata SHALL hold their last values.
REQ-033 Back-to-back non-load accepts SHALL yield one write per cycle.
REQ-034 dmem_valid SHALL be ignored in IDLE unless it coincides with a load accept.

Reset
REQ-035 Asserting rst_n low SHALL asynchronously force state IDLE and clear rf_we, rf_waddr, rf_wdata and pend_valid; pend_addr SHALL reset to 0.
REQ-036 Reset during WAIT_MEM SHALL discard the pending load with no write.
REQ-037 in_ready SHALL be high in the first cycle after reset release.

Structure
REQ-038 Package wb_pkg SHALL hold JAL_OP=6'b100000, JALR_OP=6'b010001, LB_OP=6'b010101, LBU_OP=6'b011000, LH_OP=6'b010110, LHU_OP=6'b011001, and the state enum.
REQ-039 Load extraction SHALL be a combinational sub-module, load_align (inputs: data, byte_off, aluop; output: extended data).

Verification
REQ-040 Reset then ADD with rdst=1, rd=7, alu_o=0x12345678 -> next cycle: rf_we=1, waddr=7, wdata=0x12345678.
REQ-041 LB with byte_off=2, dmem_d=0x0011F000, dmem_valid=1 -> wdata=0xFFFFFFF0; repeated with LBU -> wdata=0x000000F0.
REQ-042 LH with rt=4, dmem_valid low for 3 cycles -> in_ready=0 and pend_valid=1 with pend_addr=4 for 3 cycles; dmem_d=0x8001xxxx arrives -> wdata=0xFFFF8001.
REQ-043 JAL with alu_o=0x00400010 and rdst=0 -> waddr=31, wdata=0x00400010.
REQ-044 Write targeting r0 with rwe=1 -> rf_we stays 0; in_ready stays 1.
REQ-045 rst_n asserted during WAIT_MEM -> no write issued; IDLE and in_ready=1 after release.
